// File: rtl/pipe_order_pkg.sv
// Shared sizing and lane-pointer helpers for the in-order dispatch / put_in_order pair.
package pipe_order_pkg;

    function automatic int unsigned ptr_width_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned lane_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_lane_ptr.sv
// Round-robin lane pointer: wraps from n_lanes-1 back to 0 on each increment.
module rr_lane_ptr
    import pipe_order_pkg::*;
#(
    parameter int unsigned n_lanes   = 10,
    parameter int unsigned ptr_width = ptr_width_f(n_lanes)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [ptr_width-1:0] ptr
);

    logic [ptr_width-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_width'(lane_next(32'(ptr_q), n_lanes));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/in_order_dispatch.sv
// Issues an in-order stream round-robin to worker lanes, stalling until the next lane is free
// so results can be recombined in order downstream.
module in_order_dispatch
    import pipe_order_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned n_outputs = 10,
    parameter int unsigned ptr_width = ptr_width_f(n_outputs),
    parameter int unsigned cnt_width = cnt_width_f(n_outputs)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                up_vld,
    output logic                                up_rdy,
    input  logic [width-1:0]                    up_data,
    output logic [n_outputs-1:0]                down_vlds,
    output logic [n_outputs-1:0][width-1:0]     down_data,
    input  logic [n_outputs-1:0]                done,
    output logic [cnt_width-1:0]                in_flight,
    output logic                                err
);

    logic [ptr_width-1:0] ptr;
    logic                 fire;
    logic [n_outputs-1:0] busy_q, busy_d, issue_vec;
    logic                 err_d;
    logic [cnt_width-1:0] in_flight_d;

    rr_lane_ptr #(
        .n_lanes   (n_outputs),
        .ptr_width (ptr_width)
    ) u_ptr (
        .clk (clk),
        .rst (rst),
        .inc (fire),
        .ptr (ptr)
    );

    // Strict order: only the lane at ptr matters, never any other free lane.
    assign up_rdy = rst & ~busy_q[ptr];
    assign fire   = up_vld & up_rdy;

    always_comb begin
        issue_vec = '0;
        for (int i = 0; i < int'(n_outputs); i++) begin
            issue_vec[i] = fire && (ptr == ptr_width'(i));
        end
        // A done on an idle lane (including the lane being fired) is an error; fire wins.
        busy_d = (busy_q & ~done) | issue_vec;
        err_d  = err | (|(done & ~busy_q));
        in_flight_d = '0;
        for (int i = 0; i < int'(n_outputs); i++) begin
            in_flight_d = in_flight_d + cnt_width'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= '0;
            down_vlds <= '0;
            down_data <= '0;
            in_flight <= '0;
            err       <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            down_vlds <= issue_vec;
            in_flight <= in_flight_d;
            err       <= err_d;
            if (fire) begin
                down_data[ptr] <= up_data;
            end
        end
    end

endmodule
